d3s_phase_edge_stamper: RTL and testbench
=========================================

D3S_PHASE_EDGE_STAMPER -- requirements
Module: d3s_phase_edge_stamper

Interface
REQ-001 SHALL have parameter g_fifo_depth, default 8, meaning timestamp FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter g_holdoff, default 4, meaning cycles after an accepted crossing during which further crossings are ignored (0 = none).
REQ-003 SHALL have one clock and an asynchronous active-high reset: clk_i in 1 (125 MHz WR reference clock, all logic on its rising edge), rst_i in 1.
REQ-004 SHALL have port phase_i in 56: four 14-bit divided-RF phase lanes, lane k at [14k+13:14k], lane 0 earliest, lanes 2 ns apart.
REQ-005 SHALL have port phase_valid_i in 1: phase_i qualifier.
REQ-006 SHALL have port enable_i in 1: crossing detection enable.
REQ-007 SHALL have ports tm_time_valid_i in 1, tm_tai_i in 32, tm_cycles_i in 28: WR time, sampled in the same cycle as phase_i.
REQ-008 SHALL have ports ts_tai_o out 32, ts_nsec_o out 32, ts_valid_o out 1, ts_ready_i in 1: crossing timestamp stream.
REQ-009 SHALL have ports edge_count_o out 32 (crossings detected) and overflow_o out 1, with overflow_clr_i in 1 (sticky FIFO-overflow flag and its clear).

Function
REQ-010 SHALL define the previous sample of lane k as lane k-1 of the current word, and for lane 0 as lane 3 of the last word with phase_valid_i=1.
REQ-011 SHALL flag a lane crossing when prev[13]=1, cur[13]=0 and (prev-cur) mod 16384 >= 8192; downward motion through 8192 SHALL NOT qualify.
REQ-012 SHALL evaluate crossings only when phase_valid_i=1 and enable_i=1; lane 0 SHALL NOT qualify on the first valid word after reset or after any phase_valid_i=0 cycle.
REQ-013 SHALL, when several lanes qualify in one word, take only the lowest-numbered lane.
REQ-014 SHALL, on a taken crossing in lane k, compute ts_nsec = tm_cycles_i*8 + 2k and ts_tai = tm_tai_i, using the time sampled with that word; nsec never exceeds 999999998, so no carry into TAI is needed.
REQ-015 SHALL ignore crossings while the holdoff counter is non-zero; a taken crossing SHALL load the counter with g_holdoff, and the counter SHALL decrement once per cycle to 0.
REQ-016 SHALL increment edge_count_o (wrapping at 2^32) on each taken crossing, whether or not it is pushed.
REQ-017 SHALL push a taken crossing into the FIFO only if tm_time_valid_i=1; otherwise it is counted and discarded.
REQ-018 SHALL have a latency of 2 cycles: with the FIFO empty, a crossing in the word sampled at edge N gives ts_valid_o=1 after edge N+2.
REQ-019 SHALL operate the FIFO show-ahead: ts_valid_o = not empty; a pop occurs on ts_valid_o & ts_ready_i; outputs SHALL hold stable while ts_valid_o=1 and ts_ready_i=0.
REQ-020 SHALL, at FIFO full, accept a push only if a pop occurs in the same cycle; otherwise the entry SHALL be dropped and overflow_o set.
REQ-021 SHALL clear overflow_o on overflow_clr_i=1; a simultaneous new overflow SHALL win, leaving overflow_o=1.
REQ-022 SHALL NOT, when enable_i is deasserted, flush the FIFO; entries in the detection pipeline SHALL still be pushed.

Reset
REQ-023 SHALL, on rst_i, set ts_valid_o=0, ts_tai_o=0, ts_nsec_o=0, edge_count_o=0, overflow_o=0, the FIFO empty, the holdoff counter 0, the pipeline empty, and the previous-sample-valid flag 0.
REQ-024 SHALL discard in-flight crossings on reset asserted mid-operation, and SHALL emit no stamp in the first cycle after deassertion.

Structure
REQ-025 SHALL place c_phase_bits=14, c_lanes=4, c_ns_per_cycle=8 and c_lane_ns=2 in the shared package d3s_pkg.
REQ-026 SHALL implement the FIFO as the sub-module d3s_ts_fifo (synchronous, show-ahead, 64-bit wide, parameterised depth, full/empty outputs).

Verification
REQ-027 SHALL cover this scenario: phase ramp +1024/lane, lane 2 word = {..,16128,15104,...} to 0, tm_cycles=1000, tai=7 -> one stamp {7, 8004}, edge_count=1.
REQ-028 SHALL cover this scenario: word lanes {100, 16300, 50, 200} with previous lane 3 = 16000 -> lane 0 taken only, nsec = cycles*8+0.
REQ-029 SHALL cover this scenario: downward step lane3=8300 to lane0=8100 -> no stamp; phase_valid_i gap then lane 0 = 10 after earlier 16000 -> no stamp.
REQ-030 SHALL cover this scenario: crossings every 2 cycles, g_holdoff=4 -> only every third crossing is stamped and counted.
REQ-031 SHALL cover this scenario: ts_ready_i=0, 10 crossings, depth 8 -> 8 stored, overflow_o=1, edge_count=10; drain yields the first 8 in order; overflow_clr_i clears the flag.
REQ-032 SHALL cover this scenario: rst_i pulse 1 cycle after a crossing -> no stamp emitted and all outputs 0.

Source files
------------

// File: rtl/d3s_pkg.sv
// Shared constants, stamp record and phase-crossing helpers for the D3S
// divided-RF phase edge stamper.
package d3s_pkg;

   localparam int c_phase_bits    = 14;
   localparam int c_lanes         = 4;
   localparam int c_ns_per_cycle  = 8;
   localparam int c_lane_ns       = 2;
   localparam int c_lane_idx_bits = $clog2(c_lanes);
   localparam int c_tai_bits      = 32;
   localparam int c_nsec_bits     = 32;
   localparam int c_cycles_bits   = 28;

   typedef logic [c_phase_bits-1:0]    phase_t;
   typedef logic [c_lane_idx_bits-1:0] lane_idx_t;

   typedef struct packed {
      logic [c_tai_bits-1:0]  tai;
      logic [c_nsec_bits-1:0] nsec;
   } ts_t;

   // A wrap from the top half of the phase circle into the bottom half,
   // moving forward by at least half a turn; a slow descent through the
   // midpoint has a small modular difference and is rejected.
   function automatic logic is_crossing(input phase_t prev, input phase_t cur);
      phase_t diff;
      diff = prev - cur;
      return prev[c_phase_bits-1] & ~cur[c_phase_bits-1] & diff[c_phase_bits-1];
   endfunction

   function automatic logic [c_nsec_bits-1:0] lane_nsec(
      input logic [c_cycles_bits-1:0] cycles,
      input lane_idx_t                lane
   );
      return c_nsec_bits'(cycles) * c_nsec_bits'(c_ns_per_cycle)
           + c_nsec_bits'(lane) * c_nsec_bits'(c_lane_ns);
   endfunction

endpackage

// File: rtl/d3s_ts_fifo.sv
// Synchronous show-ahead FIFO for crossing stamps; head entry is visible on
// rd_data_o whenever empty_o is low, and reads as zero when empty.
module d3s_ts_fifo #(
   parameter int g_depth = 8,
   parameter int g_width = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wr_en_i,
   input  logic [g_width-1:0] wr_data_i,
   input  logic               rd_en_i,
   output logic [g_width-1:0] rd_data_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int c_aw = (g_depth < 2) ? 1 : $clog2(g_depth);

   logic [g_width-1:0] mem [g_depth];
   logic [c_aw-1:0]    wr_ptr;
   logic [c_aw-1:0]    rd_ptr;
   logic [c_aw:0]      count;
   logic               rd_ok;
   logic               wr_ok;

   assign empty_o = (count == '0);
   assign full_o  = (count == (c_aw+1)'(g_depth));

   // A write into a full FIFO is allowed when the head leaves in the same cycle.
   assign rd_ok = rd_en_i & ~empty_o;
   assign wr_ok = wr_en_i & (~full_o | rd_ok);

   assign rd_data_o = empty_o ? '0 : mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/d3s_phase_edge_stamper.sv
// Detects downward wraps of the divided-RF phase across four 2 ns lanes and
// stamps each accepted crossing with White Rabbit TAI / nanosecond time.
module d3s_phase_edge_stamper
   import d3s_pkg::*;
#(
   parameter int g_fifo_depth = 8,
   parameter int g_holdoff    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [55:0] phase_i,
   input  logic        phase_valid_i,
   input  logic        enable_i,
   input  logic        tm_time_valid_i,
   input  logic [31:0] tm_tai_i,
   input  logic [27:0] tm_cycles_i,
   output logic [31:0] ts_tai_o,
   output logic [31:0] ts_nsec_o,
   output logic        ts_valid_o,
   input  logic        ts_ready_i,
   output logic [31:0] edge_count_o,
   output logic        overflow_o,
   input  logic        overflow_clr_i
);

   localparam int c_hold_w = (g_holdoff < 2) ? 1 : $clog2(g_holdoff + 1);

   // Stage A: input word and the time sampled with it
   logic [55:0]   a_phase;
   logic          a_valid;
   logic          a_enable;
   logic          a_time_valid;
   logic [31:0]   a_tai;
   logic [27:0]   a_cycles;

   phase_t        prev_lane3;
   logic          prev_ok;
   logic [c_hold_w-1:0] holdoff_cnt;

   phase_t        lane_cur  [c_lanes];
   phase_t        lane_prev [c_lanes];
   logic [c_lanes-1:0] lane_cross;
   logic          eval_ok;
   logic          take;
   lane_idx_t     take_lane;

   // Stage B: stamp waiting to enter the FIFO
   logic          b_push;
   ts_t           b_stamp;

   ts_t           fifo_rd;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          drop;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_phase      <= '0;
         a_valid      <= 1'b0;
         a_enable     <= 1'b0;
         a_time_valid <= 1'b0;
         a_tai        <= '0;
         a_cycles     <= '0;
      end else begin
         a_phase      <= phase_i;
         a_valid      <= phase_valid_i;
         a_enable     <= enable_i;
         a_time_valid <= tm_time_valid_i;
         a_tai        <= tm_tai_i;
         a_cycles     <= tm_cycles_i;
      end
   end

   // Lane k compares against lane k-1; lane 0 against lane 3 of the last valid word.
   always_comb begin
      for (int k = 0; k < c_lanes; k++) begin
         lane_cur[k] = a_phase[c_phase_bits*k +: c_phase_bits];
      end
      lane_prev[0] = prev_lane3;
      for (int k = 1; k < c_lanes; k++) begin
         lane_prev[k] = lane_cur[k-1];
      end
      lane_cross[0] = prev_ok & is_crossing(lane_prev[0], lane_cur[0]);
      for (int k = 1; k < c_lanes; k++) begin
         lane_cross[k] = is_crossing(lane_prev[k], lane_cur[k]);
      end
   end

   assign eval_ok = a_valid & a_enable & (holdoff_cnt == '0);

   // Scan downward so the earliest qualifying lane wins.
   always_comb begin
      take      = 1'b0;
      take_lane = '0;
      for (int k = c_lanes - 1; k >= 0; k--) begin
         if (lane_cross[k]) begin
            take      = eval_ok;
            take_lane = lane_idx_t'(k);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_lane3 <= '0;
         prev_ok    <= 1'b0;
      end else if (a_valid) begin
         prev_lane3 <= lane_cur[c_lanes-1];
         prev_ok    <= 1'b1;
      end else begin
         prev_ok    <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         holdoff_cnt <= '0;
      end else if (take) begin
         holdoff_cnt <= c_hold_w'(g_holdoff);
      end else if (holdoff_cnt != '0) begin
         holdoff_cnt <= holdoff_cnt - 1'b1;
      end
   end

   // Crossings without valid WR time are still counted but never stamped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         b_push       <= 1'b0;
         b_stamp      <= '0;
         edge_count_o <= '0;
      end else begin
         b_push       <= take & a_time_valid;
         b_stamp.tai  <= a_tai;
         b_stamp.nsec <= lane_nsec(a_cycles, take_lane);
         if (take) begin
            edge_count_o <= edge_count_o + 1'b1;
         end
      end
   end

   d3s_ts_fifo #(
      .g_depth (g_fifo_depth),
      .g_width ($bits(ts_t))
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (b_push),
      .wr_data_i (b_stamp),
      .rd_en_i   (ts_ready_i),
      .rd_data_o (fifo_rd),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign ts_valid_o = ~fifo_empty;
   assign ts_tai_o   = fifo_rd.tai;
   assign ts_nsec_o  = fifo_rd.nsec;

   assign pop  = ts_valid_o & ts_ready_i;
   assign drop = b_push & fifo_full & ~pop;

   // A fresh drop outranks a clear in the same cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
      end else if (overflow_clr_i) begin
         overflow_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_d3s_phase_edge_stamper.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_d3s_phase_edge_stamper;

   localparam int DEPTH = 8;
   localparam int HOLD  = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [55:0] phase_i = '0;
   logic        phase_valid_i = 1'b0;
   logic        enable_i = 1'b1;
   logic        tm_time_valid_i = 1'b1;
   logic [31:0] tm_tai_i = '0;
   logic [27:0] tm_cycles_i = '0;
   logic [31:0] ts_tai_o;
   logic [31:0] ts_nsec_o;
   logic        ts_valid_o;
   logic        ts_ready_i = 1'b1;
   logic [31:0] edge_count_o;
   logic        overflow_o;
   logic        overflow_clr_i = 1'b0;

   d3s_phase_edge_stamper #(
      .g_fifo_depth (DEPTH),
      .g_holdoff    (HOLD)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .phase_i         (phase_i),
      .phase_valid_i   (phase_valid_i),
      .enable_i        (enable_i),
      .tm_time_valid_i (tm_time_valid_i),
      .tm_tai_i        (tm_tai_i),
      .tm_cycles_i     (tm_cycles_i),
      .ts_tai_o        (ts_tai_o),
      .ts_nsec_o       (ts_nsec_o),
      .ts_valid_o      (ts_valid_o),
      .ts_ready_i      (ts_ready_i),
      .edge_count_o    (edge_count_o),
      .overflow_o      (overflow_o),
      .overflow_clr_i  (overflow_clr_i)
   );

   always #4 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;
   int pops     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int unsigned at;
      logic [63:0] d;
   } ev_t;

   ev_t         pushq[$];
   int unsigned cntq[$];
   logic [63:0] mq[$];
   logic [31:0] m_cnt = '0;
   bit          m_ovf = 1'b0;
   int unsigned cyc = 0;
   bit          prev_ok = 1'b0;
   int          prev3 = 0;
   bit          has_last = 1'b0;
   int unsigned last_take = 0;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pushq.delete();
         cntq.delete();
         mq.delete();
         m_cnt    = '0;
         m_ovf    = 1'b0;
         prev_ok  = 1'b0;
         has_last = 1'b0;
      end else begin : m_step
         bit          do_pop;
         bit          novf;
         int          lanes[4];
         int          pv;
         int          tk;
         logic [31:0] ns;
         cyc++;
         do_pop = (mq.size() > 0) && ts_ready_i;
         if (do_pop) void'(mq.pop_front());
         novf = 1'b0;
         while (cntq.size() > 0 && cntq[0] == cyc) begin
            void'(cntq.pop_front());
            m_cnt = m_cnt + 32'd1;
         end
         while (pushq.size() > 0 && pushq[0].at == cyc) begin
            if (mq.size() < DEPTH) mq.push_back(pushq[0].d);
            else novf = 1'b1;
            void'(pushq.pop_front());
         end
         if (novf) m_ovf = 1'b1;
         else if (overflow_clr_i) m_ovf = 1'b0;
         if (phase_valid_i) begin
            for (int k = 0; k < 4; k++) lanes[k] = int'((phase_i >> (14 * k)) & 56'h3FFF);
            tk = -1;
            for (int k = 0; k < 4; k++) begin
               pv = (k == 0) ? prev3 : lanes[(k == 0) ? 0 : k - 1];
               if (tk < 0 && (k > 0 || prev_ok) && pv >= 8192 && lanes[k] < 8192 &&
                   ((pv - lanes[k] + 16384) % 16384) >= 8192)
                  tk = k;
            end
            if (tk >= 0 && enable_i && (!has_last || (cyc - last_take) > HOLD)) begin
               has_last  = 1'b1;
               last_take = cyc;
               cntq.push_back(cyc + 1);
               if (tm_time_valid_i) begin
                  ns = 32'(tm_cycles_i) * 32'd8 + 32'(2 * tk);
                  pushq.push_back('{cyc + 2, {tm_tai_i, ns}});
               end
            end
            prev3   = lanes[3];
            prev_ok = 1'b1;
         end else begin
            prev_ok = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_i) begin
      if (!rst_i) begin
         chk("ts_valid", {63'd0, ts_valid_o}, {63'd0, mq.size() > 0});
         if (mq.size() > 0) begin
            chk("ts_tai", {32'd0, ts_tai_o}, {32'd0, mq[0][63:32]});
            chk("ts_nsec", {32'd0, ts_nsec_o}, {32'd0, mq[0][31:0]});
         end
         chk("edge_count", {32'd0, edge_count_o}, {32'd0, m_cnt});
         chk("overflow", {63'd0, overflow_o}, {63'd0, m_ovf});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int l0, input int l1, input int l2, input int l3, input bit v);
      phase_i       = {14'(l3), 14'(l2), 14'(l1), 14'(l0)};
      phase_valid_i = v;
      if (ts_valid_o && ts_ready_i) pops++;
      @(posedge clk_i);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1'b0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      idle(2);
      rst_i = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, {63'd0, ts_valid_o}, 64'd0);
      chk({tag, "_tai"}, {32'd0, ts_tai_o}, 64'd0);
      chk({tag, "_nsec"}, {32'd0, ts_nsec_o}, 64'd0);
      chk({tag, "_count"}, {32'd0, edge_count_o}, 64'd0);
      chk({tag, "_ovf"}, {63'd0, overflow_o}, 64'd0);
   endtask

   int base;
   int step;

   initial begin
      repeat (3) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      chk_zero("reset");

      // Ramp +1024/lane; lane 2 wraps 16128 -> 0 at cycles=1000, tai=7.
      ts_ready_i = 1'b0; tm_tai_i = 32'd7; tm_cycles_i = 28'd1000;
      drive(6912, 7936, 8960, 9984, 1'b1);
      drive(11008, 12032, 13056, 14080, 1'b1);
      drive(15104, 16128, 0, 1024, 1'b1);
      idle(1);
      chk("ramp_lat_n1_valid", {63'd0, ts_valid_o}, 64'd0);
      idle(1);
      chk("ramp_lat_n2_valid", {63'd0, ts_valid_o}, 64'd1);
      chk("ramp_tai", {32'd0, ts_tai_o}, 64'd7);
      chk("ramp_nsec", {32'd0, ts_nsec_o}, 64'd8004);
      chk("ramp_count", {32'd0, edge_count_o}, 64'd1);
      ts_ready_i = 1'b1;
      idle(3);
      chk("ramp_drained", {63'd0, ts_valid_o}, 64'd0);

      // Lanes 0 and 2 both qualify: only lane 0 is taken.
      do_reset();
      ts_ready_i = 1'b0; tm_tai_i = 32'd3; tm_cycles_i = 28'd12345;
      drive(13000, 14000, 15000, 16000, 1'b1);
      drive(100, 16300, 50, 200, 1'b1);
      idle(3);
      chk("multi_valid", {63'd0, ts_valid_o}, 64'd1);
      chk("multi_tai", {32'd0, ts_tai_o}, 64'd3);
      chk("multi_nsec", {32'd0, ts_nsec_o}, 64'd98760);
      chk("multi_count", {32'd0, edge_count_o}, 64'd1);
      ts_ready_i = 1'b1;
      idle(2);
      chk("multi_single", {63'd0, ts_valid_o}, 64'd0);

      // Slow descent through 8192, then lane-0 wrap across a valid gap.
      do_reset();
      drive(8000, 8100, 8200, 8300, 1'b1);
      drive(8100, 8150, 8160, 8170, 1'b1);
      drive(16000, 16000, 16000, 16000, 1'b1);
      drive(0, 0, 0, 0, 1'b0);
      drive(10, 20, 30, 40, 1'b1);
      idle(3);
      chk("nocross_count", {32'd0, edge_count_o}, 64'd0);
      chk("nocross_valid", {63'd0, ts_valid_o}, 64'd0);

      // Crossings every 2 cycles with holdoff 4: 9 crossings -> 3 taken.
      do_reset();
      pops = 0;
      for (int i = 0; i < 9; i++) begin
         tm_cycles_i = 28'(200 + i);
         drive(16000, 16000, 16000, 16000, 1'b1);
         drive(10, 10, 10, 10, 1'b1);
      end
      idle(4);
      chk("holdoff_count", {32'd0, edge_count_o}, 64'd3);
      chk("holdoff_pops", 64'(pops), 64'd3);

      // 10 stamps into a depth-8 FIFO with no reader.
      do_reset();
      ts_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tm_tai_i = 32'(i); tm_cycles_i = 28'(100 + i);
         drive(16000, 16000, 16000, 16000, 1'b1);
         drive(10, 10, 10, 10, 1'b1);
         for (int j = 0; j < 4; j++) drive(16000, 16000, 16000, 16000, 1'b1);
      end
      idle(4);
      chk("ovf_flag", {63'd0, overflow_o}, 64'd1);
      chk("ovf_count", {32'd0, edge_count_o}, 64'd10);
      ts_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_valid", {63'd0, ts_valid_o}, 64'd1);
         chk("drain_tai", {32'd0, ts_tai_o}, 64'(i));
         chk("drain_nsec", {32'd0, ts_nsec_o}, 64'((100 + i) * 8));
         idle(1);
      end
      chk("drain_empty", {63'd0, ts_valid_o}, 64'd0);
      chk("ovf_sticky", {63'd0, overflow_o}, 64'd1);
      overflow_clr_i = 1'b1;
      idle(1);
      overflow_clr_i = 1'b0;
      chk("ovf_cleared", {63'd0, overflow_o}, 64'd0);

      // Reset one cycle after a crossing discards it.
      do_reset();
      tm_tai_i = 32'd5; tm_cycles_i = 28'd77;
      drive(16000, 16000, 16000, 16000, 1'b1);
      drive(10, 10, 10, 10, 1'b1);
      idle(1);
      rst_i = 1'b1;
      idle(1);
      rst_i = 1'b0;
      chk_zero("rstmid_first");
      idle(4);
      chk_zero("rstmid_later");

      // Randomized traffic against the model.
      do_reset();
      base = 0;
      step = 1024;
      for (int blk = 0; blk < 20; blk++) begin
         int ready_pct;
         ready_pct = (blk % 3 == 0) ? 10 : 75;
         for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 19) == 0) step = int'($urandom_range(0, 6000));
            if ($urandom_range(0, 9) == 0) base = int'($urandom_range(0, 16383));
            enable_i        = ($urandom_range(0, 99) < 90);
            tm_time_valid_i = ($urandom_range(0, 99) < 90);
            ts_ready_i      = (int'($urandom_range(0, 99)) < ready_pct);
            overflow_clr_i  = ($urandom_range(0, 99) < 3);
            tm_tai_i        = $urandom;
            tm_cycles_i     = 28'($urandom_range(0, 124999999));
            if ($urandom_range(0, 599) == 0) rst_i = 1'b1;
            drive((base) & 16383, (base + step) & 16383, (base + 2 * step) & 16383,
                  (base + 3 * step) & 16383, ($urandom_range(0, 99) < 85));
            rst_i = 1'b0;
            base = (base + 4 * step) & 16383;
         end
      end
      enable_i = 1'b1; tm_time_valid_i = 1'b1; overflow_clr_i = 1'b0; ts_ready_i = 1'b1;
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
